// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to a 1-cycle
// latency instruction memory, buffers returned instructions with their PCs,
// and presents them to decode over a valid/ready handshake. A redirect
// flushes all speculative fetch state. Halt stops new fetches.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    output logic        inst_req,
    input  logic [31:0] inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        align_err,
    output logic        fetch_idle
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_r;
    logic [31:0]   req_pc_r;
    logic          inflight_r;
    logic          align_err_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [31:0]   inst_q_r [QDEPTH];
    logic [31:0]   pc_q_r   [QDEPTH];

    logic [CW:0]   occupancy_s;
    logic          enq_s;
    logic          deq_s;
    logic          req_s;

    // Credit check, handshake qualification and request generation.
    always_comb begin
        occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        req_s       = 1'b0;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        if (!rst && !halt && !redirect_valid && (occupancy_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (!rst && !redirect_valid) begin
            // A response whose request preceded a redirect is discarded here.
            enq_s = inflight_r;
            deq_s = (count_r != {CW{1'b0}}) && dec_ready;
        end else begin
            enq_s = 1'b0;
            deq_s = 1'b0;
        end
    end

    // PC, in-flight tracking, queue pointers/occupancy and alignment flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            req_pc_r    <= RESET_PC;
            inflight_r  <= 1'b0;
            align_err_r <= 1'b0;
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else if (redirect_valid) begin
            pc_r        <= {redirect_pc[31:2], 2'b00};
            inflight_r  <= 1'b0;
            align_err_r <= |redirect_pc[1:0];
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else begin
            align_err_r <= 1'b0;
            inflight_r  <= req_s;
            if (req_s) begin
                pc_r     <= pc_r + 32'd4;
                req_pc_r <= pc_r;
            end
            if (enq_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (deq_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: the returning instruction is written with the PC it came from.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            inst_q_r[tail_r] <= inst;
            pc_q_r[tail_r]   <= req_pc_r;
        end
    end

    assign inst_addr  = pc_r;
    assign inst_req   = req_s;
    assign dec_valid  = (count_r != {CW{1'b0}});
    assign dec_inst   = inst_q_r[head_r];
    assign dec_pc     = pc_q_r[head_r];
    assign align_err  = align_err_r;
    assign fetch_idle = (count_r == {CW{1'b0}}) && !inflight_r;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: a 1-cycle memory model, a
// scoreboard of expected PCs pushed at request time and popped on each
// decode handshake, and directed checks for latency, backpressure,
// redirect, misalignment, halt, PC wrap and mid-run reset.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        align_err;
    logic        fetch_idle;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] sb_q [$];
    logic [31:0] exp_pc;
    logic        align_pend = 1'b0;
    bit          mon_en     = 1'b0;

    riscv_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_req       (inst_req),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .align_err      (align_err),
        .fetch_idle     (fetch_idle)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_dec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dec_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: data for an accepted request appears one cycle later.
    always @(posedge clk) inst <= inst_req ? inst_of(inst_addr) : 32'hDEAD_BEEF;

    // Scoreboard monitor, evaluated mid-cycle on the transfer about to happen.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("align_err", align_err, align_pend);
            check_eq("fetch_idle", fetch_idle, sb_q.size() == 0);
            if (sb_q.size() == 0) check_eq("dec_valid_empty", dec_valid, 1'b0);
            if (rst) begin
                check_eq("req_in_rst", inst_req, 1'b0);
                sb_q.delete();
                exp_pc     = RST_PC;
                align_pend = 1'b0;
            end else if (redirect_valid) begin
                check_eq("req_in_redirect", inst_req, 1'b0);
                sb_q.delete();
                exp_pc     = {redirect_pc[31:2], 2'b00};
                align_pend = |redirect_pc[1:0];
            end else begin
                align_pend = 1'b0;
                if (dec_valid && dec_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", 1'b1, 1'b0);
                    end else begin
                        logic [31:0] e;
                        e = sb_q.pop_front();
                        check_eq("dec_pc", dec_pc, e);
                        check_eq("dec_inst", dec_inst, inst_of(e));
                    end
                end
                if (inst_req) begin
                    check_eq("inst_addr", inst_addr, exp_pc);
                    sb_q.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int dv;
        bit ok;
        bit found;
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        check_eq("rst_dec_valid", dec_valid, 1'b0);
        check_eq("rst_fetch_idle", fetch_idle, 1'b1);
        check_eq("rst_inst_addr", inst_addr, RST_PC);

        // 1: streaming after reset release.
        rst = 1'b0;
        first = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_req) begin first = cyc; break; end
        end
        check_eq("t1_first_addr", inst_addr, 32'h0);
        dv = -1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dec_valid) begin dv = cyc; break; end
        end
        check_eq("t1_latency", 32'(dv - first), 32'd2);
        check_eq("t1_dec_pc0", dec_pc, 32'h0);
        check_eq("t1_dec_inst0", dec_inst, 32'h0000_0013);
        repeat (8) tick();

        // 2: backpressure fills the queue, release drains it in order.
        do_reset();
        dec_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check_eq("t2_req_full", inst_req, 1'b0);
        check_eq("t2_dec_valid", dec_valid, 1'b1);
        check_eq("t2_head_stable", dec_pc, 32'h0);
        check_eq("t2_not_idle", fetch_idle, 1'b0);
        tick();
        dec_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_release_head", dec_pc, 32'h0);
        repeat (8) tick();

        // 3: redirect while fetch of 0x8 is in flight.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_req && inst_addr == 32'h8) begin found = 1'b1; break; end
        end
        check_eq("t3_found_8", found, 1'b1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_dec_valid_r1", dec_valid, 1'b0);
        wait_dec(ok);
        check_eq("t3_timeout", ok, 1'b1);
        check_eq("t3_dec_pc", dec_pc, 32'h100);

        // 4: misaligned redirect target.
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_align_err", align_err, 1'b1);
        check_eq("t4_inst_req", inst_req, 1'b1);
        check_eq("t4_inst_addr", inst_addr, 32'h200);
        tick();
        @(negedge clk);
        check_eq("t4_align_pulse", align_err, 1'b0);
        wait_dec(ok);
        check_eq("t4_timeout", ok, 1'b1);
        check_eq("t4_dec_pc", dec_pc, 32'h200);

        // 5: halt mid-stream, then redirect while halted and PC wrap.
        repeat (3) tick();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t5_halt_req", inst_req, 1'b0);
        end
        tick();
        halt = 1'b0;
        @(negedge clk);
        check_eq("t5_resume_req", inst_req, 1'b1);
        repeat (4) tick();
        halt = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_halted_redirect_req", inst_req, 1'b0);
        tick();
        halt = 1'b0;
        @(negedge clk);
        check_eq("t5_wrap_start", inst_addr, 32'hFFFF_FFF8);
        check_eq("t5_wrap_req", inst_req, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dec_valid && dec_pc == 32'h0) begin found = 1'b1; break; end
        end
        check_eq("t5_wrap_to_zero", found, 1'b1);
        repeat (4) tick();

        // 6: reset with the queue 3/4 full and a fetch in flight.
        do_reset();
        dec_ready = 1'b0;
        wait_dec(ok);
        check_eq("t6_timeout", ok, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_dec_valid", dec_valid, 1'b0);
        check_eq("t6_inst_addr", inst_addr, RST_PC);
        check_eq("t6_inst_req", inst_req, 1'b1);
        check_eq("t6_fetch_idle", fetch_idle, 1'b1);
        tick();
        dec_ready = 1'b1;
        wait_dec(ok);
        check_eq("t6_timeout2", ok, 1'b1);
        check_eq("t6_dec_pc", dec_pc, RST_PC);
        check_eq("t6_dec_inst", dec_inst, inst_of(RST_PC));
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
